// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of CHANNELS programmable 50%-duty clock dividers.
// Configuration arrives as a serial frame: shifted in while cfg_en_i is high
// and committed on the falling edge of cfg_en_i. A commit with the wrong bit
// count is rejected and flagged on the sticky cfg_err_o. Every good commit
// restarts all channels together, so enabled outputs stay phase aligned.
// Frame layout, first bit shifted first: channel CHANNELS-1 down to channel 0,
// and each channel sends {en, div[CNT_W-1:0]} with en first.
// Optional build macro: CLK_DIV_BANK_READBACK_EN drives the shift register MSB
// out on cfg_data_o, registered, so several banks can be daisy-chained.
// Without the macro, cfg_data_o is tied low.
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             cfg_en_i,
    input  logic                                             cfg_data_i,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_i,
    output logic [CHANNELS-1:0]                              div_clk_o,
    output logic [CNT_W-1:0]                                 sel_count_o,
    output logic                                             cfg_err_o,
    output logic                                             cfg_data_o
);
    localparam int CW    = CNT_W + 1;
    localparam int FRAME = CHANNELS * CW;
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BC_W  = $clog2(FRAME + 2);

    logic [FRAME-1:0] shreg;
    logic [FRAME-1:0] active_cfg;
    logic [BC_W-1:0]  bit_cnt;
    logic             cfg_en_q;
    logic [CNT_W-1:0] cnt [CHANNELS];
    logic [CNT_W-1:0] sel_cnt;
    logic             commit;
    logic             good_commit;

    // A commit is the first edge that sees cfg_en_i low after it was high.
    assign commit      = cfg_en_q & ~cfg_en_i;
    assign good_commit = commit && (bit_cnt == BC_W'(FRAME));

    // Serial front end: shift, count bits, and take or reject the frame on commit.
    // After a good commit the shift register already holds the config just made
    // active, so the next frame pushes that config out first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            cfg_en_q   <= 1'b0;
            active_cfg <= '0;
            cfg_err_o  <= 1'b0;
        end else begin
            cfg_en_q <= cfg_en_i;
            if (cfg_en_i) begin
                shreg <= {shreg[FRAME-2:0], cfg_data_i};
                // Saturate just past FRAME so overlong frames can never alias a good count.
                if (bit_cnt != BC_W'(FRAME + 1)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (commit) begin
                bit_cnt <= '0;
                if (good_commit) begin
                    active_cfg <= shreg;
                    cfg_err_o  <= 1'b0;
                end else begin
                    cfg_err_o  <= 1'b1;
                end
            end
        end
    end

    // Divider counters: all restart from zero on a good commit, else count to div and toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            div_clk_o <= '0;
        end else if (good_commit) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            div_clk_o <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!active_cfg[i*CW + CNT_W]) begin
                    cnt[i]       <= '0;
                    div_clk_o[i] <= 1'b0;
                end else if (cnt[i] == active_cfg[i*CW +: CNT_W]) begin
                    cnt[i]       <= '0;
                    div_clk_o[i] <= ~div_clk_o[i];
                end else begin
                    cnt[i]       <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Counter select; codes beyond the last channel read as zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    // Register the selected counter so the pad sees a clean value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_count_o <= '0;
        end else begin
            sel_count_o <= sel_cnt;
        end
    end

`ifdef CLK_DIV_BANK_READBACK_EN
    // Readback: shift register MSB, registered, for daisy-chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_data_o <= 1'b0;
        end else begin
            cfg_data_o <= shreg[FRAME-1];
        end
    end
`else
    assign cfg_data_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank (CHANNELS=4, CNT_W=8, FRAME=36).
// The reference model derives divider outputs from the number of edges since
// the last good commit: cnt = n mod (div+1), clk = floor(n/(div+1)) mod 2.
module tb_clk_div_bank;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int CW       = CNT_W + 1;
    localparam int FRAME    = CHANNELS * CW;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b1;
    logic                cfg_en_i   = 1'b0;
    logic                cfg_data_i = 1'b0;
    logic [1:0]          sel_i      = 2'd0;
    logic [CHANNELS-1:0] div_clk_o;
    logic [CNT_W-1:0]    sel_count_o;
    logic                cfg_err_o;
    logic                cfg_data_o;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    clk_div_bank #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en_i   (cfg_en_i),
        .cfg_data_i (cfg_data_i),
        .sel_i      (sel_i),
        .div_clk_o  (div_clk_o),
        .sel_count_o(sel_count_o),
        .cfg_err_o  (cfg_err_o),
        .cfg_data_o (cfg_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FRAME-1:0] m_cfg  = '0;
    logic [FRAME-1:0] m_sh   = '0;
    int               m_n    = 0;
    int               m_bits = 0;
    bit               m_en_q = 1'b0;
    bit               m_err  = 1'b0;
    bit               m_rb   = 1'b0;
    logic [CNT_W-1:0] m_sel  = '0;

    function automatic bit ch_en(input logic [FRAME-1:0] c, input int i);
        return c[i*CW + CNT_W];
    endfunction

    function automatic int ch_div(input logic [FRAME-1:0] c, input int i);
        return int'(c[i*CW +: CNT_W]);
    endfunction

    function automatic int model_cnt(input int i);
        if (i >= CHANNELS || !ch_en(m_cfg, i)) return 0;
        return m_n % (ch_div(m_cfg, i) + 1);
    endfunction

    function automatic logic [CHANNELS-1:0] model_clk();
        logic [CHANNELS-1:0] r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_en(m_cfg, i)) r[i] = ((m_n / (ch_div(m_cfg, i) + 1)) % 2) == 1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cfg = '0; m_sh = '0; m_n = 0; m_bits = 0;
            m_en_q = 1'b0; m_err = 1'b0; m_rb = 1'b0; m_sel = '0;
        end else begin
            m_sel = CNT_W'(model_cnt(int'(sel_i)));
            m_rb  = m_sh[FRAME-1];
            if (cfg_en_i) begin
                m_sh = {m_sh[FRAME-2:0], cfg_data_i};
                m_bits++;
                m_n++;
            end else if (m_en_q) begin
                if (m_bits == FRAME) begin
                    m_cfg = m_sh;
                    m_n   = 0;
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                    m_n++;
                end
                m_bits = 0;
            end else begin
                m_n++;
            end
            m_en_q = cfg_en_i;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("div_clk", 64'(div_clk_o), 64'(model_clk()));
            check("sel_count", 64'(sel_count_o), 64'(m_sel));
            check("cfg_err", 64'(cfg_err_o), 64'(m_err));
`ifdef CLK_DIV_BANK_READBACK_EN
            check("cfg_data", 64'(cfg_data_o), 64'(m_rb));
`else
            check("cfg_data", 64'(cfg_data_o), 64'(0));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic shift_bits(input logic [FRAME-1:0] f, input int nbits);
        for (int k = nbits - 1; k >= 0; k--) begin
            cfg_en_i   = 1'b1;
            cfg_data_i = f[k];
            @(negedge clk);
        end
        cfg_en_i   = 1'b0;
        cfg_data_i = 1'b0;
    endtask

    logic [FRAME-1:0] fa = 36'h829DE05FF;
    logic [FRAME-1:0] fb = 36'h123456789;
    logic [3:0]       t3_clk [9] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0010,
                                     4'b0110, 4'b0010, 4'b0110, 4'b0000};
    logic [7:0]       t3_sel [9] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    logic [3:0]       t5_clk [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    logic [7:0]       t5_sel [5] = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

    initial begin
        // 1: reset state, then idle
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("rst div_clk", 64'(div_clk_o), 64'(0));
        check("rst sel_count", 64'(sel_count_o), 64'(0));
        check("rst cfg_err", 64'(cfg_err_o), 64'(0));
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle div_clk", 64'(div_clk_o), 64'(0));

        // 2: ch0 {1,0} -> clk/2
        shift_bits(36'h000000100, FRAME);
        @(negedge clk);
        check("t2 n0 div_clk", 64'(div_clk_o), 64'(4'b0000));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t2 toggle", 64'(div_clk_o), 64'((k % 2 == 1) ? 4'b0001 : 4'b0000));
        end

        // 3: ch1 {1,3}, ch2 {1,0}, watch ch1 counter
        sel_i = 2'd1;
        shift_bits(36'h004020600, FRAME);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("t3 div_clk", 64'(div_clk_o), 64'(t3_clk[k]));
            check("t3 sel_count", 64'(sel_count_o), 64'(t3_sel[k]));
        end
        repeat (10) @(negedge clk);

        // 4: short frame rejected, good frame clears, 1-bit frame rejected
        shift_bits(36'hFFFFFFFFF, FRAME - 1);
        @(negedge clk);
        check("t4 short err", 64'(cfg_err_o), 64'(1));
        repeat (9) @(negedge clk);
        shift_bits(36'h004020600, FRAME);
        @(negedge clk);
        check("t4 good err", 64'(cfg_err_o), 64'(0));
        check("t4 good restart", 64'(div_clk_o), 64'(0));
        repeat (5) @(negedge clk);
        shift_bits(36'h000000001, 1);
        @(negedge clk);
        check("t4 1bit err", 64'(cfg_err_o), 64'(1));
        repeat (7) @(negedge clk);

        // 5: reset mid-frame and mid-period
        for (int k = 0; k < 20; k++) begin
            cfg_en_i   = 1'b1;
            cfg_data_i = k[0];
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        cfg_en_i = 1'b0;
        #1;
        check("t5 async div_clk", 64'(div_clk_o), 64'(0));
        check("t5 async err", 64'(cfg_err_o), 64'(0));
        check("t5 async sel", 64'(sel_count_o), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sel_i = 2'd3;
        shift_bits(36'h808000000, FRAME);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5 div_clk", 64'(div_clk_o), 64'(t5_clk[k]));
            check("t5 sel_count", 64'(sel_count_o), 64'(t5_sel[k]));
        end

        // 6: frame A with ch0 div=255, then frame B pushes A back out
        sel_i = 2'd0;
        shift_bits(fa, FRAME);
        @(negedge clk);
        repeat (255) @(negedge clk);
        check("t6 max div n255", 64'(div_clk_o[0]), 64'(0));
        check("t6 max cnt n255", 64'(sel_count_o), 64'(254));
        @(negedge clk);
        check("t6 max div n256", 64'(div_clk_o[0]), 64'(1));
        check("t6 max cnt n256", 64'(sel_count_o), 64'(255));
        for (int k = FRAME - 1; k >= 0; k--) begin
            cfg_en_i   = 1'b1;
            cfg_data_i = fb[k];
            @(negedge clk);
`ifdef CLK_DIV_BANK_READBACK_EN
            check("t6 readback", 64'(cfg_data_o), 64'(fa[k]));
`endif
        end
        cfg_en_i   = 1'b0;
        cfg_data_i = 1'b0;
        @(negedge clk);
        check("t6 commit err", 64'(cfg_err_o), 64'(0));
        repeat (30) @(negedge clk);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
